mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the single-cycle request bus driven by the team's compute initiators (matmul and similar): mem_req, mem_write, mem_addr, mem_wdata out of the initiator; mem_rdata_vld, mem_rdata back.
- Holds a word-addressed RAM window and commits writes.
- Returns read data after a fixed latency, flags out-of-window accesses, and keeps access statistics.
- Used as the bench/FPGA memory for initiator blocks; it has no backpressure, so it accepts one request every cycle.

Parameters:
- MEM_AW, 16, request address width
- MEM_DW, 32, data width
- DEPTH_AW, 10, log2 of words stored (DEPTH_AW <= MEM_AW)
- BASE, 0, first address of the mapped window
- RD_LAT, 2, read latency in cycles, >= 1
- ERR_DATA, 32'hDEADBEEF, data returned for out-of-window reads
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- mem_req  in  1  request valid; each high cycle is one transaction
- mem_write  in  1  1 = write, 0 = read; sampled with mem_req
- mem_addr  in  MEM_AW  word address
- mem_wdata  in  MEM_DW  write data
- mem_rdata_vld  out  1  one-cycle pulse, read data valid
- mem_rdata  out  MEM_DW  read data
- mem_err  out  1  one-cycle pulse, out-of-window access accepted
- stat_clr  in  1  synchronous clear of counters
- wr_cnt  out  CNT_W  accepted in-window writes, saturating
- rd_cnt  out  CNT_W  accepted reads (including out-of-window), saturating
- rd_pending  out  $clog2(RD_LAT+1)  reads in flight

Behaviour:
- Reset (async, rst=1): mem_rdata_vld=0, mem_rdata=0, mem_err=0, wr_cnt=0, rd_cnt=0, rd_pending=0. The read pipeline is flushed, so in-flight reads are dropped and never return. RAM contents are not reset.
- Accept: every rising edge with mem_req=1 is one transaction. There is no ready signal. Back-to-back requests every cycle are legal.
- Window: hit when BASE <= mem_addr < BASE+2^DEPTH_AW. Compute the comparison with one extra bit so that BASE+2^DEPTH_AW does not wrap. RAM index = (mem_addr-BASE)[DEPTH_AW-1:0].
- Write hit: RAM[index] <= mem_wdata at edge N. A read accepted at N+1 returns the new value.
- Write miss: dropped, RAM unchanged, mem_err=1 during cycle N+1 only.
- Read hit: RAM is sampled at edge N. mem_rdata_vld=1 and mem_rdata=data during cycle N+RD_LAT only.
- Read miss: returns ERR_DATA with mem_rdata_vld=1 at N+RD_LAT. mem_err pulses at N+1.
- Read pipeline: RD_LAT-stage shift register of {valid, data}. One read return per cycle maximum, and order is preserved.
- mem_rdata holds its last value when mem_rdata_vld=0.
- rd_pending: +1 on a read accept, -1 on a return, net 0 when both happen in the same cycle.
- Counters: increment on the relevant accept and saturate at all-ones. If stat_clr and an accept occur in the same cycle, the result is 0 (clear wins).
- mem_write and mem_wdata are don't-care when mem_req=0.
- X on mem_addr while mem_req=1 is a bench error.
- Control: one small FSM, IDLE/ACTIVE. It moves to ACTIVE on any accept and returns to IDLE when rd_pending=0 and mem_req=0. It is exposed only for assertions; data-path behaviour does not depend on it.

Decomposition:
- Shared package mem_bus_pkg:
  - request/response field widths and ERR_DATA
  - the window-hit function
  - so initiators and the responder agree on them
- One natural sub-module, rd_delay_pipe: a parameterised RD_LAT-deep valid/data shift register with in-flight count.
- RAM is an inferred array in the top module.

Test Plan:
- Write then read: write addr BASE+5 data 32'h12345678, next cycle read BASE+5 -> mem_rdata_vld at +RD_LAT with 32'h12345678, wr_cnt=1, rd_cnt=1.
- Streaming: initiator pattern MEM_write(BASE+i+1, ~(i+1)) for i=0..7, then back-to-back reads every cycle -> 8 consecutive vld pulses, in order, data ~(i+1), rd_pending peaks at RD_LAT.
- Window edges: read BASE-1 and BASE+2^DEPTH_AW -> ERR_DATA with vld, mem_err pulse each. Read BASE+2^DEPTH_AW-1 -> stored data, no err.
- Write miss: write BASE+2^DEPTH_AW -> mem_err=1 one cycle, wr_cnt unchanged, and RAM index 0 unchanged (no alias).
- Reset mid-flight: issue 2 reads, assert rst one cycle after -> no vld pulses ever appear, rd_pending=0. RAM data survives and is verified by a post-reset read.
- Counters: force 2^CNT_W+3 writes -> wr_cnt=all-ones. stat_clr with a simultaneous write -> 0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared request-bus definitions for compute initiators and the memory responder.
// Holds default field widths, the error read pattern and the address-window test.
package mem_bus_pkg;

  localparam int MEM_AW_DEF   = 16;
  localparam int MEM_DW_DEF   = 32;
  localparam int DEPTH_AW_DEF = 10;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } resp_state_e;

  // Evaluated at 64 bits so that base + 2**depth_aw cannot wrap for any bus width below 64.
  function automatic logic win_hit(input logic [63:0] addr, input logic [63:0] base,
                                   input int depth_aw);
    logic [63:0] span;
    span = 64'd1 << depth_aw;
    return (addr >= base) && (addr < (base + span));
  endfunction

endpackage

// File: rtl/mem_responder_rd_delay_pipe.sv
// Fixed-latency valid/data shift register carrying read returns, with in-flight count.
// Each stage loads only on a valid input, so the last stage holds its data between returns.
module rd_delay_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 2,
  localparam int PW = $clog2(LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  output logic [PW-1:0] pending
);

  logic [LAT-1:0] vld_q;
  logic [DW-1:0]  data_q [LAT];
  logic [LAT-1:0] src_vld_s;
  logic [DW-1:0]  src_data_s [LAT];
  logic [PW-1:0]  pend_q;
  logic [PW-1:0]  pend_d;

  always_comb begin
    src_vld_s[0]  = in_vld;
    src_data_s[0] = in_data;
    for (int i = 1; i < LAT; i++) begin
      src_vld_s[i]  = vld_q[i-1];
      src_data_s[i] = data_q[i-1];
    end
  end

  // A return leaves the count on the edge that ends its output pulse.
  always_comb begin
    pend_d = pend_q + PW'(in_vld) - PW'(vld_q[LAT-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      pend_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q  <= src_vld_s;
      pend_q <= pend_d;
      for (int i = 0; i < LAT; i++) begin
        if (src_vld_s[i]) begin
          data_q[i] <= src_data_s[i];
        end
      end
    end
  end

  assign out_vld  = vld_q[LAT-1];
  assign out_data = data_q[LAT-1];
  assign pending  = pend_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the single-cycle initiator request bus: RAM window,
// fixed-latency read returns, out-of-window error pulses and saturating statistics.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int                MEM_AW   = MEM_AW_DEF,
  parameter int                MEM_DW   = MEM_DW_DEF,
  parameter int                DEPTH_AW = DEPTH_AW_DEF,
  parameter logic [MEM_AW-1:0] BASE     = '0,
  parameter int                RD_LAT   = 2,
  parameter logic [MEM_DW-1:0] ERR_DATA = MEM_DW'(DEF_ERR_DATA),
  parameter int                CNT_W    = 16,
  localparam int               PEND_W   = $clog2(RD_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  output logic              mem_err,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [PEND_W-1:0] rd_pending
);

  logic [MEM_DW-1:0]   ram_q [2**DEPTH_AW];
  logic                hit_s;
  logic                wr_hit_s;
  logic                rd_acc_s;
  logic [DEPTH_AW-1:0] idx_s;
  logic [MEM_DW-1:0]   rd_data_s;
  logic                err_q;
  logic [CNT_W-1:0]    wr_cnt_q;
  logic [CNT_W-1:0]    wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q;
  logic [CNT_W-1:0]    rd_cnt_d;
  resp_state_e         state_q;

  assign hit_s     = win_hit(64'(mem_addr), 64'(BASE), DEPTH_AW);
  assign idx_s     = DEPTH_AW'(mem_addr - BASE);
  assign wr_hit_s  = mem_req & mem_write & hit_s;
  assign rd_acc_s  = mem_req & ~mem_write;
  assign rd_data_s = hit_s ? ram_q[idx_s] : ERR_DATA;

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_hit_s) begin
      ram_q[idx_s] <= mem_wdata;
    end
  end

  rd_delay_pipe #(
    .DW  (MEM_DW),
    .LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_acc_s),
    .in_data  (rd_data_s),
    .out_vld  (mem_rdata_vld),
    .out_data (mem_rdata),
    .pending  (rd_pending)
  );

  // Clear has priority over a same-cycle accept.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (stat_clr) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      if (wr_hit_s && (wr_cnt_q != '1)) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
      if (rd_acc_s && (rd_cnt_q != '1)) begin
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end else begin
        rd_cnt_d = rd_cnt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      err_q    <= mem_req & ~hit_s;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Activity tracker observed only by assertion checkers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_q <= mem_req ? ST_ACTIVE : ST_IDLE;
        ST_ACTIVE: state_q <= (!mem_req && (rd_pending == '0)) ? ST_IDLE : ST_ACTIVE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_err = err_q;
  assign wr_cnt  = wr_cnt_q;
  assign rd_cnt  = rd_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a relocated window (BASE = 0x1000) and RD_LAT = 2.
module tb_mem_responder;

  localparam logic [15:0] B   = 16'h1000;
  localparam logic [15:0] TOP = 16'h1400;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdata_vld;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        stat_clr;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
  logic [1:0]  rd_pending;

  int n_assert;
  int n_fail;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        exp_vld;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  mem_responder #(
    .MEM_AW   (16),
    .MEM_DW   (32),
    .DEPTH_AW (10),
    .BASE     (B),
    .RD_LAT   (2),
    .ERR_DATA (32'hDEADBEEF),
    .CNT_W    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata_vld (mem_rdata_vld),
    .mem_rdata     (mem_rdata),
    .mem_err       (mem_err),
    .stat_clr      (stat_clr),
    .wr_cnt        (wr_cnt),
    .rd_cnt        (rd_cnt),
    .rd_pending    (rd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic wr, input logic [15:0] a, input logic [31:0] d);
    mem_req   = req;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int seen;
    int first_t;
    int last_t;
    int vld_hits;
    logic [1:0] max_p;

    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    stat_clr = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 32'h0);

    vecs[0]  = '{1'b1, B + 16'd5,   32'h87654321, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, B + 16'd5,   32'h0,        1'b0, 1'b1, 32'h87654321};
    vecs[2]  = '{1'b1, B,           32'hAAAA5555, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, TOP,         32'h0BADF00D, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, B,           32'h0,        1'b0, 1'b1, 32'hAAAA5555};
    vecs[5]  = '{1'b0, B - 16'd1,   32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, TOP,         32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, TOP - 16'd1, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, TOP - 16'd1, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 16'hFFFF,    32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 16'h0000,    32'h0,        1'b1, 1'b1, 32'hDEADBEEF};

    repeat (2) tick();
    chk("rst_vld",     32'(mem_rdata_vld), 32'h0);
    chk("rst_rdata",   mem_rdata,          32'h0);
    chk("rst_err",     32'(mem_err),       32'h0);
    chk("rst_wr_cnt",  32'(wr_cnt),        32'h0);
    chk("rst_rd_cnt",  32'(rd_cnt),        32'h0);
    chk("rst_pending", 32'(rd_pending),    32'h0);
    rst = 1'b0;
    tick();

    // Write followed immediately by a read of the same word.
    drive(1'b1, 1'b1, B + 16'd5, 32'h12345678);
    tick();
    drive(1'b1, 1'b0, B + 16'd5, 32'h0);
    tick();
    chk("wr_rd_early_vld", 32'(mem_rdata_vld), 32'h0);
    drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    chk("wr_rd_vld",     32'(mem_rdata_vld), 32'h1);
    chk("wr_rd_data",    mem_rdata,          32'h12345678);
    chk("wr_rd_wr_cnt",  32'(wr_cnt),        32'h1);
    chk("wr_rd_rd_cnt",  32'(rd_cnt),        32'h1);
    chk("wr_rd_pending", 32'(rd_pending),    32'h1);
    tick();
    chk("wr_rd_vld_end",  32'(mem_rdata_vld), 32'h0);
    chk("wr_rd_hold",     mem_rdata,          32'h12345678);
    chk("wr_rd_pend_end", 32'(rd_pending),    32'h0);

    // Single isolated transactions from the table.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      tick();
      chk($sformatf("vec%0d_err", i), 32'(mem_err), 32'(vecs[i].exp_err));
      drive(1'b0, 1'b0, 16'h0, 32'h0);
      tick();
      chk($sformatf("vec%0d_err_off", i), 32'(mem_err), 32'h0);
      chk($sformatf("vec%0d_vld", i), 32'(mem_rdata_vld), 32'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) begin
        chk($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
      end
      tick();
      chk($sformatf("vec%0d_pending", i), 32'(rd_pending), 32'h0);
    end
    chk("table_wr_cnt", 32'(wr_cnt), 32'd4);
    chk("table_rd_cnt", 32'(rd_cnt), 32'd8);

    // Streaming writes, then back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, B + 16'(i + 1), ~32'(i + 1));
      tick();
    end
    seen    = 0;
    first_t = -1;
    last_t  = -1;
    max_p   = 2'd0;
    for (int t = 0; t < 12; t++) begin
      if (t < 8) drive(1'b1, 1'b0, B + 16'(t + 1), 32'h0);
      else       drive(1'b0, 1'b0, 16'h0, 32'h0);
      tick();
      if (rd_pending > max_p) max_p = rd_pending;
      if (mem_rdata_vld) begin
        chk($sformatf("stream_data%0d", seen), mem_rdata, ~32'(seen + 1));
        if (first_t < 0) first_t = t;
        last_t = t;
        seen++;
      end
    end
    chk("stream_count",  32'(seen),             32'd8);
    chk("stream_contig", 32'(last_t - first_t), 32'd7);
    chk("stream_peak",   32'(max_p),            32'd2);
    chk("stream_wr_cnt", 32'(wr_cnt),           32'd12);
    chk("stream_rd_cnt", 32'(rd_cnt),           32'd16);

    // Reset while two reads are in flight.
    drive(1'b1, 1'b0, B + 16'd5, 32'h0);
    tick();
    drive(1'b1, 1'b0, B + 16'd1, 32'h0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 32'h0);
    rst = 1'b1;
    vld_hits = 0;
    tick();
    if (mem_rdata_vld) vld_hits++;
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (mem_rdata_vld) vld_hits++;
    end
    chk("flush_no_vld",  32'(vld_hits),   32'd0);
    chk("flush_pending", 32'(rd_pending), 32'h0);
    chk("flush_rdata",   mem_rdata,       32'h0);
    chk("flush_wr_cnt",  32'(wr_cnt),     32'h0);
    drive(1'b1, 1'b0, B + 16'd1, 32'h0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    chk("post_rst_vld",  32'(mem_rdata_vld), 32'h1);
    chk("post_rst_data", mem_rdata,          32'hFFFFFFFE);
    tick();

    // Saturation, then clear racing a write.
    drive(1'b1, 1'b1, B + 16'd7, 32'h5A5A5A5A);
    repeat (65539) tick();
    chk("sat_wr_cnt", 32'(wr_cnt), 32'h0000FFFF);
    chk("sat_rd_cnt", 32'(rd_cnt), 32'h1);
    stat_clr = 1'b1;
    tick();
    chk("clr_wr_cnt", 32'(wr_cnt), 32'h0);
    chk("clr_rd_cnt", 32'(rd_cnt), 32'h0);
    stat_clr = 1'b0;
    tick();
    chk("after_clr_wr_cnt", 32'(wr_cnt), 32'h1);
    drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
